// File: rtl/assembler_constants.sv
// Shared RV32I encoding constants and decoded-instruction types used by the
// assembler flow and the instruction decoder.
package assembler_constants;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_t;

  typedef enum logic {RUN, HALT} state_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [4:0]  funct5;
    logic [31:0] imm;
  } InstFields;

  typedef struct packed {
    logic [7:0] line;
    logic       error_flag;
  } Error;

endpackage

// File: rtl/inst_field_decode.sv
// Combinational RV32I field extraction, immediate sign extension and
// legality check for a single instruction word.
module inst_field_decode
  import assembler_constants::*;
(
  input  logic [31:0] word,
  output InstFields   fields,
  output logic        illegal
);

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  fmt_t       fmt;

  assign op = word[6:0];
  assign f3 = word[14:12];
  assign f7 = word[31:25];

  always_comb begin
    illegal = 1'b0;
    fmt     = FMT_R;
    case (op)
      OP_REG: begin
        fmt     = FMT_R;
        illegal = !(f7 == F7_ZERO || f7 == F7_ALT) ||
                  (f7 == F7_ALT && !(f3 == F3_ADD_SUB || f3 == F3_SR));
      end
      OP_IMM: begin
        fmt     = FMT_I;
        illegal = (f3 == F3_SLL && f7 != F7_ZERO) ||
                  (f3 == F3_SR && !(f7 == F7_ZERO || f7 == F7_ALT));
      end
      OP_LOAD: begin
        fmt     = FMT_I;
        illegal = (f3 == F3_SLTU) || (f3 == F3_OR) || (f3 == F3_AND);
      end
      OP_STORE: begin
        fmt     = FMT_S;
        illegal = (f3 > F3_SLT);
      end
      OP_BRANCH: begin
        fmt     = FMT_B;
        illegal = (f3 == F3_SLT) || (f3 == F3_SLTU);
      end
      OP_JAL:  fmt = FMT_J;
      OP_JALR: begin
        fmt     = FMT_I;
        illegal = (f3 != F3_ADD_SUB);
      end
      OP_LUI, OP_AUIPC: fmt = FMT_U;
      default: illegal = 1'b1;
    endcase
  end

  // Start from the raw bit fields, then zero whatever the format does not use.
  always_comb begin
    fields        = '0;
    fields.opcode = op;
    fields.rd     = word[11:7];
    fields.funct3 = f3;
    fields.rs1    = word[19:15];
    fields.rs2    = word[24:20];
    fields.funct7 = f7;
    fields.funct5 = word[31:27];
    case (fmt)
      FMT_R: fields.imm = '0;
      FMT_I: begin
        fields.rs2    = '0;
        fields.funct7 = '0;
        fields.funct5 = '0;
        fields.imm    = {{20{word[31]}}, word[31:20]};
      end
      FMT_S: begin
        fields.rd  = '0;
        fields.imm = {{20{word[31]}}, word[31:25], word[11:7]};
      end
      FMT_B: begin
        fields.rd  = '0;
        fields.imm = {{20{word[31]}}, word[7], word[30:25], word[11:8], 1'b0};
      end
      FMT_U: begin
        fields.rs1    = '0;
        fields.rs2    = '0;
        fields.funct3 = '0;
        fields.funct7 = '0;
        fields.funct5 = '0;
        fields.imm    = {word[31:12], 12'b0};
      end
      FMT_J: begin
        fields.rs1    = '0;
        fields.rs2    = '0;
        fields.funct3 = '0;
        fields.funct7 = '0;
        fields.funct5 = '0;
        fields.imm    = {{12{word[31]}}, word[19:12], word[20], word[30:21], 1'b0};
      end
      default: fields.imm = '0;
    endcase
  end

endmodule

// File: rtl/inst_decoder.sv
// Valid/ready instruction decoder: one-cycle registered output, line counter
// and an error state that can halt intake until cleared.
module inst_decoder
  import assembler_constants::*;
#(
  parameter bit STOP_ON_ERROR = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [31:0] inst_data_in,
  input  logic        inst_valid_in,
  output logic        inst_ready_out,
  output InstFields   fields_out,
  output logic        fields_valid_out,
  input  logic        fields_ready_in,
  output Error        error_out,
  input  logic        clear_in
);

  InstFields dec_fields;
  logic      dec_illegal;
  logic      accept;
  logic [7:0] line_cnt;
  state_t    state, state_nxt;

  inst_field_decode u_decode (
    .word    (inst_data_in),
    .fields  (dec_fields),
    .illegal (dec_illegal)
  );

  assign inst_ready_out = (state == RUN) && !clear_in &&
                          (!fields_valid_out || fields_ready_in);
  assign accept = inst_valid_in && inst_ready_out;

  // Output register: load on a legal accept, otherwise empty once drained.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fields_valid_out <= 1'b0;
      fields_out       <= '0;
    end else if (accept && !dec_illegal) begin
      fields_out       <= dec_fields;
      fields_valid_out <= 1'b1;
    end else if (fields_ready_in) begin
      fields_valid_out <= 1'b0;
    end
  end

  // The error line records the count before this word's increment.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      line_cnt  <= '0;
      error_out <= '0;
    end else if (clear_in) begin
      line_cnt  <= '0;
      error_out <= '0;
    end else if (accept) begin
      line_cnt <= line_cnt + 8'd1;
      if (dec_illegal) begin
        error_out.line       <= line_cnt;
        error_out.error_flag <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= RUN;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (accept && dec_illegal && STOP_ON_ERROR) state_nxt = HALT;
      HALT:    if (clear_in) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

endmodule

// File: doc/inst_decoder.md
INST_DECODER -- requirements
Module: inst_decoder

Interface
REQ-001 The module SHALL take parameter STOP_ON_ERROR, default 1, which when 1 makes an illegal word halt intake until cleared.
REQ-002 The module SHALL have port clk_in, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port rst_n_in, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have port inst_data_in, input, 32 bits: the RV32I instruction word.
REQ-005 The module SHALL have port inst_valid_in, input, 1 bit: inst_data_in is valid.
REQ-006 The module SHALL have port inst_ready_out, output, 1 bit: the decoder accepts a word this cycle.
REQ-007 The module SHALL have port fields_out, output, InstFields: the decoded fields.
REQ-008 The module SHALL have port fields_valid_out, output, 1 bit: fields_out is valid.
REQ-009 The module SHALL have port fields_ready_in, input, 1 bit: the downstream consumer takes fields_out.
REQ-010 The module SHALL have port error_out, output, Error: the line number of the illegal word plus a sticky error_flag.
REQ-011 The module SHALL have port clear_in, input, 1 bit: a synchronous clear of the error state and the line counter.

Function
REQ-012 A word SHALL be accepted when inst_valid_in && inst_ready_out.
REQ-013 inst_ready_out SHALL be (state==RUN) && !clear_in && (!fields_valid_out || fields_ready_in).
REQ-014 Latency SHALL be 1 cycle: a legal word accepted in cycle N appears on fields_out with fields_valid_out=1 in cycle N+1.
REQ-015 The output register SHALL hold fields_out and fields_valid_out stable while fields_valid_out && !fields_ready_in, so no word is lost or duplicated.
REQ-016 fields_valid_out SHALL drop after a transfer when no new legal word is accepted in the same cycle.
REQ-017 Accept and drain in the same cycle SHALL give full throughput.
REQ-018 Field extraction SHALL be: opcode=[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25], funct5=[31:27].
REQ-019 Fields not used by the word's format SHALL be driven to 0:
- R-type has imm=0.
- U-type and J-type have rs1=rs2=funct3=funct7=funct5=0.
- I-type has rs2=funct7=funct5=0.
- S-type and B-type have rd=0.
REQ-020 imm SHALL be sign-extended to 32 bits as follows:
- I-type: [31:20].
- S-type: {[31:25],[11:7]}.
- B-type: {[31],[7],[30:25],[11:8],0}.
- U-type: {[31:12],12'b0}.
- J-type: {[31],[19:12],[20],[30:21],0}.
REQ-021 A word SHALL be illegal if any of the following holds:
- opcode is not one of REG, IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
- REG with funct7 not in {0000000,0100000}, or with funct7=0100000 and funct3 not in {000,101}.
- IMM with funct3=001 and funct7!=0, or with funct3=101 and funct7 not in {0000000,0100000}.
- LOAD with funct3 in {011,110,111}.
- STORE with funct3>010.
- BRANCH with funct3 in {010,011}.
- JALR with funct3!=000.
REQ-022 An illegal word SHALL be consumed and never emitted on fields_out.
REQ-023 On an illegal word, error_out.line SHALL take the line count and error_out.error_flag SHALL be set to 1 the next cycle.
REQ-024 The line counter SHALL be 8 bits, start at 0, increment on every accepted word (legal or illegal), and wrap from 255 to 0.
REQ-025 The state machine SHALL have two states, RUN and HALT:
- RUN→HALT on an accepted illegal word when STOP_ON_ERROR=1.
- HALT→RUN on clear_in.
- With STOP_ON_ERROR=0 the state stays RUN, and a later illegal word overwrites error_out.line.
REQ-026 clear_in SHALL have priority over acceptance:
- The line counter goes to 0.
- error_out goes to 0.
- The state goes to RUN.
- Any pending fields_out SHALL still be held and drained normally.

Reset
REQ-027 While rst_n_in=0, all of the following SHALL be forced immediately, independent of clk_in:
- state=RUN.
- fields_valid_out=0.
- fields_out=0.
- error_out=0.
- The line counter=0.
REQ-028 A reset mid-transfer SHALL discard the pending output word.
REQ-029 Operation SHALL resume on the first rising edge of clk_in after rst_n_in returns to 1.

Structure
REQ-030 InstFields, Error, the OP_*, F3_* and F7_* constants, and the format enum (R, I, S, B, U, J) SHALL come from the shared assembler_constants package, and no constant SHALL be redefined locally.
REQ-031 The decode and legality check SHALL be one combinational sub-module, inst_field_decode (input: word; outputs: InstFields and illegal).
REQ-032 inst_decoder SHALL hold only the handshake logic, the output register, the counter and the state machine.

Verification
REQ-033 add x3,x1,x2: input 0x002081B3 SHALL produce, one cycle later, opcode=0110011, rd=3, rs1=1, rs2=2, funct3=0, funct7=0, imm=0.
REQ-034 Sign extension: addi x1,x0,-1 (0xFFF00093) SHALL give imm=0xFFFFFFFF; beq x0,x0,-4 (0xFE000EE3) SHALL give imm=0xFFFFFFFC; lui x5,0x12345 (0x123452B7) SHALL give imm=0x12345000 and rd=5.
REQ-035 Backpressure: with fields_ready_in held low for 3 cycles during a burst of 4 words, the 4 words SHALL be received in order, unchanged and with no duplicates; inst_ready_out SHALL be 0 while the register is full and not draining.
REQ-036 Error halt: legal, legal, 0xFFFFFFFF SHALL give error_out={line=2, flag=1}, then inst_ready_out=0 with 2 words emitted; after a clear_in pulse, error_out=0, the line counter=0, and intake resumes.
REQ-037 Wrap and mid-stream reset: after 256 legal accepts the counter SHALL read 0; asserting rst_n_in=0 while fields_valid_out=1 SHALL drive fields_valid_out=0 with no clock edge.
